// File: rtl/sci_counter_p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sci_counter_p : approximate event counter reporting base x RADIX^exponent
// Rev 1.0
// ---------------------------------------------------------------------------
module sci_counter_p #(
  parameter int RADIX       = 10,
  parameter int MANT_DIGITS = 2,
  parameter int EXP_MAX     = 9,
  parameter int EXP_W       = 4,
  parameter int PRE_W       = 30,
  parameter bit SATURATE    = 1'b1,
  localparam int MMAX       = RADIX ** MANT_DIGITS,
  localparam int MMIN       = RADIX ** (MANT_DIGITS - 1),
  localparam int MANT_W     = $clog2(MMAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              snap,
  output logic [MANT_W-1:0] base,
  output logic [EXP_W-1:0]  exponent,
  output logic              tick,
  output logic              exp_step,
  output logic              ovf,
  output logic [MANT_W-1:0] snap_base,
  output logic [EXP_W-1:0]  snap_exponent,
  output logic              snap_valid
);

  localparam logic [MANT_W-1:0] BASE_TOP = MANT_W'(MMAX - 1);
  localparam logic [MANT_W-1:0] BASE_MIN = MANT_W'(MMIN);
  localparam logic [EXP_W-1:0]  EXP_TOP  = EXP_W'(EXP_MAX);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0]  RADIX_P  = PRE_W'(RADIX);

  logic [MANT_W-1:0] base_q, base_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [PRE_W-1:0]  thr_q, thr_d;
  logic              ovf_q, ovf_d;
  logic              tick_q, tick_d;
  logic              exp_step_q, exp_step_d;
  logic [MANT_W-1:0] snap_base_q, snap_base_d;
  logic [EXP_W-1:0]  snap_exp_q, snap_exp_d;
  logic              snap_valid_q, snap_valid_d;

  logic [PRE_W:0]    pre_inc;
  logic              pre_wrap;
  logic              base_last;
  logic              exp_last;
  logic              halted;

  assign pre_inc   = {1'b0, pre_q} + {{PRE_W{1'b0}}, 1'b1};
  assign pre_wrap  = (pre_inc == {1'b0, thr_q});
  assign base_last = (base_q == BASE_TOP);
  assign exp_last  = (exp_q == EXP_TOP);
  // A saturated counter ignores events until cleared.
  assign halted    = SATURATE && ovf_q;

  always_comb begin
    base_d       = base_q;
    exp_d        = exp_q;
    pre_d        = pre_q;
    thr_d        = thr_q;
    ovf_d        = ovf_q;
    tick_d       = 1'b0;
    exp_step_d   = 1'b0;
    snap_base_d  = snap_base_q;
    snap_exp_d   = snap_exp_q;
    snap_valid_d = snap_valid_q;

    if (snap) begin
      snap_base_d  = base_q;
      snap_exp_d   = exp_q;
      snap_valid_d = 1'b1;
    end

    if (clr) begin
      base_d = '0;
      exp_d  = '0;
      pre_d  = '0;
      thr_d  = PRE_ONE;
      ovf_d  = 1'b0;
    end else if (en && !halted) begin
      if (pre_wrap) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (base_last) begin
          if (exp_last) begin
            ovf_d = 1'b1;
            if (SATURATE) begin
              base_d = BASE_TOP;
              exp_d  = EXP_TOP;
            end else begin
              base_d = '0;
              exp_d  = '0;
              thr_d  = PRE_ONE;
            end
          end else begin
            base_d     = BASE_MIN;
            exp_d      = exp_q + EXP_W'(1);
            thr_d      = thr_q * RADIX_P;
            exp_step_d = 1'b1;
          end
        end else begin
          base_d = base_q + MANT_W'(1);
        end
      end else begin
        pre_d = pre_inc[PRE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q       <= '0;
      exp_q        <= '0;
      pre_q        <= '0;
      thr_q        <= PRE_ONE;
      ovf_q        <= 1'b0;
      tick_q       <= 1'b0;
      exp_step_q   <= 1'b0;
      // A snapshot taken on the reset edge still captures the pre-edge count.
      snap_base_q  <= snap ? base_q : '0;
      snap_exp_q   <= snap ? exp_q : '0;
      snap_valid_q <= 1'b0;
    end else begin
      base_q       <= base_d;
      exp_q        <= exp_d;
      pre_q        <= pre_d;
      thr_q        <= thr_d;
      ovf_q        <= ovf_d;
      tick_q       <= tick_d;
      exp_step_q   <= exp_step_d;
      snap_base_q  <= snap_base_d;
      snap_exp_q   <= snap_exp_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign base          = base_q;
  assign exponent      = exp_q;
  assign tick          = tick_q;
  assign exp_step      = exp_step_q;
  assign ovf           = ovf_q;
  assign snap_base     = snap_base_q;
  assign snap_exponent = snap_exp_q;
  assign snap_valid    = snap_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sci_counter_p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sci_counter_p : bench for sci_counter_p (default, radix-2 saturate, radix-2 wrap)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sci_counter_p;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, clr = 1'b0, snap = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] b0, sb0;  logic [3:0] e0, se0;  logic t0, x0, o0, v0;
  logic [1:0] b1, sb1;  logic [1:0] e1, se1;  logic t1, x1, o1, v1;
  logic [1:0] b2, sb2;  logic [1:0] e2, se2;  logic t2, x2, o2, v2;

  sci_counter_p u0 (.clk(clk), .rst(rst), .en(en), .clr(clr), .snap(snap),
    .base(b0), .exponent(e0), .tick(t0), .exp_step(x0), .ovf(o0),
    .snap_base(sb0), .snap_exponent(se0), .snap_valid(v0));
  sci_counter_p #(.RADIX(2), .MANT_DIGITS(2), .EXP_MAX(2), .EXP_W(2), .PRE_W(4), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .snap(snap),
    .base(b1), .exponent(e1), .tick(t1), .exp_step(x1), .ovf(o1),
    .snap_base(sb1), .snap_exponent(se1), .snap_valid(v1));
  sci_counter_p #(.RADIX(2), .MANT_DIGITS(2), .EXP_MAX(2), .EXP_W(2), .PRE_W(4), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .snap(snap),
    .base(b2), .exponent(e2), .tick(t2), .exp_step(x2), .ovf(o2),
    .snap_base(sb2), .snap_exponent(se2), .snap_valid(v2));

  int checks = 0;
  int errors = 0;

  int R[3]    = '{10, 2, 2};
  int MD[3]   = '{2, 2, 2};
  int EM[3]   = '{9, 2, 2};
  int SATP[3] = '{1, 1, 0};

  // Model state: events counted since the last clear, plus snapshot/pulse expectations.
  longint n[3]  = '{0, 0, 0};
  longint sb[3] = '{0, 0, 0};
  longint se[3] = '{0, 0, 0};
  bit     sv[3] = '{0, 0, 0};
  bit     tk[3] = '{0, 0, 0};
  bit     es[3] = '{0, 0, 0};

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint ipow(input int r, input int k);
    longint p = 1;
    for (int j = 0; j < k; j++) p = p * r;
    return p;
  endfunction

  // Number of events from zero until the overflow event (inclusive).
  function automatic longint period_of(input int i);
    longint mmax = ipow(R[i], MD[i]);
    longint mmin = ipow(R[i], MD[i] - 1);
    longint p = mmax;
    for (int k = 1; k <= EM[i]; k++) p = p + (mmax - mmin) * ipow(R[i], k);
    return p;
  endfunction

  // Displayed (base, exponent) after n events, derived from the stage lengths.
  function automatic void decode(input int i, input longint cnt, output longint b, output longint e);
    longint mmax = ipow(R[i], MD[i]);
    longint mmin = ipow(R[i], MD[i] - 1);
    longint per  = period_of(i);
    longint m    = (SATP[i] == 0) ? (cnt % per) : cnt;
    longint rem, p, span;
    b = m; e = 0;
    if (m < mmax) return;
    rem = m - mmax;
    for (int k = 1; k <= EM[i]; k++) begin
      p = ipow(R[i], k);
      span = (mmax - mmin) * p;
      if (rem < span) begin
        b = mmin + rem / p; e = k; return;
      end
      if (k == EM[i]) begin
        b = mmax - 1; e = EM[i]; return;
      end
      rem = rem - span;
    end
  endfunction

  task automatic compare_all();
    longint ab[3], ae[3], at[3], ax[3], ao[3], asb[3], ase[3], av[3];
    longint b, e;
    ab  = '{longint'(b0), longint'(b1), longint'(b2)};
    ae  = '{longint'(e0), longint'(e1), longint'(e2)};
    at  = '{longint'(t0), longint'(t1), longint'(t2)};
    ax  = '{longint'(x0), longint'(x1), longint'(x2)};
    ao  = '{longint'(o0), longint'(o1), longint'(o2)};
    asb = '{longint'(sb0), longint'(sb1), longint'(sb2)};
    ase = '{longint'(se0), longint'(se1), longint'(se2)};
    av  = '{longint'(v0), longint'(v1), longint'(v2)};
    for (int i = 0; i < 3; i++) begin
      decode(i, n[i], b, e);
      chk($sformatf("u%0d.base", i), ab[i], b);
      chk($sformatf("u%0d.exponent", i), ae[i], e);
      chk($sformatf("u%0d.tick", i), at[i], longint'(tk[i]));
      chk($sformatf("u%0d.exp_step", i), ax[i], longint'(es[i]));
      chk($sformatf("u%0d.ovf", i), ao[i], (n[i] >= period_of(i)) ? 1 : 0);
      chk($sformatf("u%0d.snap_base", i), asb[i], sb[i]);
      chk($sformatf("u%0d.snap_exponent", i), ase[i], se[i]);
      chk($sformatf("u%0d.snap_valid", i), av[i], longint'(sv[i]));
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit e, input bit s);
    longint pb, pe, nb, ne, per;
    rst = r; clr = c; en = e; snap = s;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      per = period_of(i);
      decode(i, n[i], pb, pe);
      tk[i] = 1'b0; es[i] = 1'b0;
      if (r) begin
        n[i] = 0; sb[i] = s ? pb : 0; se[i] = s ? pe : 0; sv[i] = 1'b0;
      end else begin
        if (s) begin sb[i] = pb; se[i] = pe; sv[i] = 1'b1; end
        if (c) n[i] = 0;
        else if (e && !(SATP[i] == 1 && n[i] >= per)) begin
          n[i] = n[i] + 1;
          decode(i, n[i], nb, ne);
          tk[i] = (nb != pb) || (ne != pe) || (n[i] % per == 0);
          es[i] = (ne > pe);
        end
      end
    end
    #1;
    compare_all();
  endtask

  task automatic run_events(input int k);
    for (int j = 0; j < k; j++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    int ev;
    int b0, e0;
    int b1, e1, o1;
    int b2, e2, o2;
  } vec_t;

  initial begin
    vec_t tbl[7];
    tbl[0] = '{3, 3, 0, 3, 0, 0, 3, 0, 0};
    tbl[1] = '{1, 4, 0, 2, 1, 0, 2, 1, 0};
    tbl[2] = '{4, 8, 0, 2, 2, 0, 2, 2, 0};
    tbl[3] = '{4, 12, 0, 3, 2, 0, 3, 2, 0};
    tbl[4] = '{4, 16, 0, 3, 2, 1, 0, 0, 1};
    tbl[5] = '{1, 17, 0, 3, 2, 1, 1, 0, 1};
    tbl[6] = '{3, 20, 0, 3, 2, 1, 2, 1, 1};

    // Reset for two cycles, then a reset pulse between edges must be ignored.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.base", longint'(b0), 0);
    chk("rst.snap_valid", longint'(v0), 0);
    run_events(5);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("glitch.base", longint'(b0), 5);

    // Radix-2 saturate/wrap table plus the default counter alongside.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      run_events(tbl[k].ev);
      chk($sformatf("tbl%0d.u0.base", k), longint'(b0), tbl[k].b0);
      chk($sformatf("tbl%0d.u0.exp", k), longint'(e0), tbl[k].e0);
      chk($sformatf("tbl%0d.u1.base", k), longint'(b1), tbl[k].b1);
      chk($sformatf("tbl%0d.u1.exp", k), longint'(e1), tbl[k].e1);
      chk($sformatf("tbl%0d.u1.ovf", k), longint'(o1), tbl[k].o1);
      chk($sformatf("tbl%0d.u2.base", k), longint'(b2), tbl[k].b2);
      chk($sformatf("tbl%0d.u2.exp", k), longint'(e2), tbl[k].e2);
      chk($sformatf("tbl%0d.u2.ovf", k), longint'(o2), tbl[k].o2);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr.u2.ovf", longint'(o2), 0);
    chk("clr.u1.ovf", longint'(o1), 0);

    // Default counter, en held: first exponent step at event 100.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_events(99);
    chk("s2.base99", longint'(b0), 99);
    chk("s2.exp99", longint'(e0), 0);
    run_events(1);
    chk("s2.base100", longint'(b0), 10);
    chk("s2.exp100", longint'(e0), 1);
    chk("s2.exp_step100", longint'(x0), 1);
    run_events(9);
    chk("s2.exp_step_gone", longint'(x0), 0);
    chk("s2.tick109", longint'(t0), 0);
    run_events(1);
    chk("s2.base110", longint'(b0), 11);
    chk("s2.tick110", longint'(t0), 1);

    // Same event count with en active one cycle in three.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 110; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("s3.base", longint'(b0), 11);
    chk("s3.exp", longint'(e0), 1);

    // Reach (42,3), then clr+en+snap on one edge, then reset drops snap_valid.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    run_events(42000);
    chk("s6.base", longint'(b0), 42);
    chk("s6.exp", longint'(e0), 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("s6.clr_base", longint'(b0), 0);
    chk("s6.clr_exp", longint'(e0), 0);
    chk("s6.snap_base", longint'(sb0), 42);
    chk("s6.snap_exp", longint'(se0), 3);
    chk("s6.snap_valid", longint'(v0), 1);
    run_events(5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s6.rst_snap_valid", longint'(v0), 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      bit r, c, e, s;
      r = ($urandom % 256) == 0;
      c = ($urandom % 64) == 0;
      e = ($urandom % 2) == 0;
      s = !r && (($urandom % 8) == 0);
      cyc(r, c, e, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
